// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if
// Bundles the requester, redirect and instruction-memory signals of the
// instruction memory port arbiter.
//   master : testbench / SoC side. Drives FetchReq, FetchAddr, Flush,
//            DbgReq, DbgAddr and MemInst; observes grants, responses
//            and MemAddr.
//   slave  : the arbiter itself (opposite directions).
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              FetchReq;
    logic [ADDR_W-1:0] FetchAddr;
    logic              Flush;
    logic              FetchGrant;
    logic              FetchValid;
    logic [31:0]       FetchInst;
    logic              DbgReq;
    logic [ADDR_W-1:0] DbgAddr;
    logic              DbgGrant;
    logic              DbgValid;
    logic [31:0]       DbgInst;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemInst;

    modport master (
        output FetchReq, FetchAddr, Flush, DbgReq, DbgAddr, MemInst,
        input  FetchGrant, FetchValid, FetchInst,
        input  DbgGrant, DbgValid, DbgInst, MemAddr
    );

    modport slave (
        input  FetchReq, FetchAddr, Flush, DbgReq, DbgAddr, MemInst,
        output FetchGrant, FetchValid, FetchInst,
        output DbgGrant, DbgValid, DbgInst, MemAddr
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares the single combinational instruction memory read port between the
// IF-stage fetch unit and the debug/monitor reader. Each cycle at most one
// requester is granted; the word returned by the memory is registered into
// the winner's Inst register and flagged valid for exactly one cycle.
// A starvation counter forces a debug slot after STARVE_LIMIT consecutive
// fetch wins while debug waits, and Flush suppresses a fetch grant.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous, active-low reset
//   bus    : imem_port_arbiter_if.slave (requests, grants, responses,
//            memory address/data)
module imem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_port_arbiter_if.slave    bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic              fetch_ok;
    logic              fetch_grant;
    logic              dbg_grant;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        starve_cnt;
    logic [3:0]        starve_cnt_next;
    logic              fetch_valid;
    logic              dbg_valid;
    logic [31:0]       fetch_inst;
    logic [31:0]       dbg_inst;

    // Grant selection and address mux. Grants are held low while in reset
    // so nothing downstream sees a port owner during reset.
    always_comb begin
        fetch_ok    = bus.FetchReq & ~bus.Flush;
        fetch_grant = 1'b0;
        dbg_grant   = 1'b0;
        mem_addr    = '0;
        if (rst_n) begin
            if (bus.DbgReq && ((starve_cnt == LIMIT) || !fetch_ok)) begin
                dbg_grant = 1'b1;
            end else if (fetch_ok) begin
                fetch_grant = 1'b1;
            end
        end
        if (dbg_grant) begin
            mem_addr = {bus.DbgAddr[ADDR_W-1:2], 2'b00};
        end else if (fetch_grant) begin
            mem_addr = {bus.FetchAddr[ADDR_W-1:2], 2'b00};
        end
    end

    // Starvation counter: counts fetch wins while debug is waiting and
    // saturates at the limit, which is what forces the debug slot.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (dbg_grant || !bus.DbgReq) begin
            starve_cnt_next = 4'd0;
        end else if (fetch_grant && (starve_cnt < LIMIT)) begin
            starve_cnt_next = starve_cnt + 4'd1;
        end
    end

    // Response registers: the loser keeps its previous instruction word,
    // only its valid flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt  <= 4'd0;
            fetch_valid <= 1'b0;
            dbg_valid   <= 1'b0;
            fetch_inst  <= 32'd0;
            dbg_inst    <= 32'd0;
        end else begin
            starve_cnt  <= starve_cnt_next;
            fetch_valid <= fetch_grant;
            dbg_valid   <= dbg_grant;
            if (fetch_grant) begin
                fetch_inst <= bus.MemInst;
            end
            if (dbg_grant) begin
                dbg_inst <= bus.MemInst;
            end
        end
    end

    assign bus.FetchGrant = fetch_grant;
    assign bus.DbgGrant   = dbg_grant;
    assign bus.MemAddr    = mem_addr;
    assign bus.FetchValid = fetch_valid;
    assign bus.FetchInst  = fetch_inst;
    assign bus.DbgValid   = dbg_valid;
    assign bus.DbgInst    = dbg_inst;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter
// Directed vector table for the documented scenarios, a hand-written reset
// sequence, and a randomized phase compared against a cycle-level model of
// the arbitration rules. The instruction memory is a small array indexed by
// MemAddr[7:2].
module tb_imem_port_arbiter;

    localparam int LIMIT = 4;

    logic clk;
    logic rst_n;

    imem_port_arbiter_if #(.ADDR_W(32)) bus ();

    imem_port_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .ADDR_W(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] imem [0:63];
    assign bus.MemInst = imem[bus.MemAddr[7:2]];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        fl;
        logic        dr;
        logic [31:0] da;
        logic        eFg;
        logic        eDg;
        logic [31:0] eMa;
        logic        eFv;
        logic [31:0] eFi;
        logic        eDv;
        logic [31:0] eDi;
    } vec_t;

    vec_t vecs [15];

    // Reference model state for the random phase.
    int          mWait;
    logic        mFv;
    logic [31:0] mFi;
    logic        mDv;
    logic [31:0] mDi;
    logic        curFr;
    logic [31:0] curFa;
    logic        curDr;
    logic [31:0] curDa;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [31:0] fa, input logic fl,
                         input logic dr, input logic [31:0] da);
        bus.FetchReq  = fr;
        bus.FetchAddr = fa;
        bus.Flush     = fl;
        bus.DbgReq    = dr;
        bus.DbgAddr   = da;
    endtask

    task automatic checkAll(input string tag, input logic fg, input logic dg, input logic [31:0] ma,
                            input logic fv, input logic [31:0] fi, input logic dv, input logic [31:0] di);
        checkOutput({tag, ".FetchGrant"}, {31'd0, bus.FetchGrant}, {31'd0, fg});
        checkOutput({tag, ".DbgGrant"},   {31'd0, bus.DbgGrant},   {31'd0, dg});
        checkOutput({tag, ".MemAddr"},    bus.MemAddr,             ma);
        checkOutput({tag, ".FetchValid"}, {31'd0, bus.FetchValid}, {31'd0, fv});
        checkOutput({tag, ".FetchInst"},  bus.FetchInst,           fi);
        checkOutput({tag, ".DbgValid"},   {31'd0, bus.DbgValid},   {31'd0, dv});
        checkOutput({tag, ".DbgInst"},    bus.DbgInst,             di);
    endtask

    task automatic applyStimulus(input int idx);
        @(negedge clk);
        drive(vecs[idx].fr, vecs[idx].fa, vecs[idx].fl, vecs[idx].dr, vecs[idx].da);
        #1;
        checkAll($sformatf("vec%0d", idx), vecs[idx].eFg, vecs[idx].eDg, vecs[idx].eMa,
                 vecs[idx].eFv, vecs[idx].eFi, vecs[idx].eDv, vecs[idx].eDi);
    endtask

    // One randomized cycle: pick legal inputs, predict, compare, advance model.
    task automatic randomCycle(input int cyc);
        logic        fl;
        logic        fetchOk;
        logic        dbgWins;
        logic        fetchWins;
        logic [31:0] ma;
        @(negedge clk);
        if (!curFr && ($urandom_range(0, 3) != 0)) begin
            curFr = 1'b1;
            curFa = $urandom;
        end
        if (!curDr && ($urandom_range(0, 2) == 0)) begin
            curDr = 1'b1;
            curDa = $urandom;
        end
        fl = ($urandom_range(0, 4) == 0);
        drive(curFr, curFa, fl, curDr, curDa);
        #1;
        fetchOk   = curFr && !fl;
        dbgWins   = curDr && (mWait >= LIMIT || !fetchOk);
        fetchWins = !dbgWins && fetchOk;
        ma        = dbgWins ? (curDa & ~32'h3) : fetchWins ? (curFa & ~32'h3) : 32'h0;
        checkAll($sformatf("rnd%0d", cyc), fetchWins, dbgWins, ma, mFv, mFi, mDv, mDi);
        mFv = fetchWins;
        mDv = dbgWins;
        if (fetchWins) mFi = imem[ma[7:2]];
        if (dbgWins)   mDi = imem[ma[7:2]];
        if (dbgWins || !curDr) mWait = 0;
        else if (fetchWins)    mWait = (mWait + 1 > LIMIT) ? LIMIT : mWait + 1;
        if (fetchWins) curFr = 1'b0;
        if (dbgWins)   curDr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'hC0DE0000 + i;
        imem[0]  = 32'h08100001;
        imem[1]  = 32'h20080005;
        imem[2]  = 32'h20090005;
        imem[3]  = 32'h11080001;
        imem[22] = 32'h08100005;
        imem[23] = 32'h00000000;

        //            fr  fa     fl  dr  da     Fg  Dg  Ma     Fv  Fi            Dv  Di
        vecs[0]  = '{1, 32'h00, 0, 0, 32'h00, 1, 0, 32'h00, 0, 32'h00000000, 0, 32'h00000000};
        vecs[1]  = '{1, 32'h04, 0, 0, 32'h00, 1, 0, 32'h04, 1, 32'h08100001, 0, 32'h00000000};
        vecs[2]  = '{1, 32'h08, 0, 0, 32'h00, 1, 0, 32'h08, 1, 32'h20080005, 0, 32'h00000000};
        vecs[3]  = '{1, 32'h0C, 0, 0, 32'h00, 1, 0, 32'h0C, 1, 32'h20090005, 0, 32'h00000000};
        vecs[4]  = '{0, 32'h00, 0, 0, 32'h00, 0, 0, 32'h00, 1, 32'h11080001, 0, 32'h00000000};
        vecs[5]  = '{1, 32'h10, 0, 1, 32'h58, 1, 0, 32'h10, 0, 32'h11080001, 0, 32'h00000000};
        vecs[6]  = '{1, 32'h10, 0, 1, 32'h58, 1, 0, 32'h10, 1, 32'hC0DE0004, 0, 32'h00000000};
        vecs[7]  = '{1, 32'h10, 0, 1, 32'h58, 1, 0, 32'h10, 1, 32'hC0DE0004, 0, 32'h00000000};
        vecs[8]  = '{1, 32'h10, 0, 1, 32'h58, 1, 0, 32'h10, 1, 32'hC0DE0004, 0, 32'h00000000};
        vecs[9]  = '{1, 32'h10, 0, 1, 32'h58, 0, 1, 32'h58, 1, 32'hC0DE0004, 0, 32'h00000000};
        vecs[10] = '{1, 32'h10, 0, 0, 32'h00, 1, 0, 32'h10, 0, 32'hC0DE0004, 1, 32'h08100005};
        vecs[11] = '{1, 32'h14, 1, 1, 32'h5E, 0, 1, 32'h5C, 1, 32'hC0DE0004, 0, 32'h08100005};
        vecs[12] = '{1, 32'h14, 0, 0, 32'h00, 1, 0, 32'h14, 0, 32'hC0DE0004, 1, 32'h00000000};
        vecs[13] = '{0, 32'h00, 1, 0, 32'h00, 0, 0, 32'h00, 1, 32'hC0DE0005, 0, 32'h00000000};
        vecs[14] = '{0, 32'h00, 0, 0, 32'h00, 0, 0, 32'h00, 0, 32'hC0DE0005, 0, 32'h00000000};

        // Reset state, with a live fetch request that must not be granted.
        rst_n = 1'b0;
        drive(1'b1, 32'h40, 1'b0, 1'b1, 32'h44);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkAll("reset", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 15; i++) applyStimulus(i);

        // Reset pulse during a fetch grant: the in-flight response is dropped.
        @(negedge clk);
        drive(1'b1, 32'h18, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("rstseq.grant", {31'd0, bus.FetchGrant}, 32'd1);
        checkOutput("rstseq.addr", bus.MemAddr, 32'h18);
        #2 rst_n = 1'b0;
        #1;
        checkAll("rstseq.asserted", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkAll("rstseq.after", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Randomized phase from a fresh reset.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        mWait = 0;
        mFv = 1'b0; mFi = 32'h0;
        mDv = 1'b0; mDi = 32'h0;
        curFr = 1'b0; curFa = 32'h0;
        curDr = 1'b0; curDa = 32'h0;
        for (int c = 0; c < 600; c++) randomCycle(c);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single combinational instruction memory read port between two requesters:
  - the IF-stage fetch unit;
  - the debug/monitor reader used for program dump over the board interface.
- Arbitrates every cycle and drives the memory address.
- Registers the returned instruction so each requester sees a one-cycle, valid-flagged response.
- Includes a starvation guard for the debug port and a flush input that kills an in-flight fetch after a branch or jump redirect.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive cycles the debug port may wait while fetch wins before debug is forced to win (legal range 1..15).
- ADDR_W, 32: byte-address width of both requester ports and MemAddr.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- FetchReq  in  1  fetch request; held with stable FetchAddr until granted
- FetchAddr  in  ADDR_W  fetch byte address (PC)
- Flush  in  1  redirect: blocks fetch grant this cycle
- FetchGrant  out  1  combinational; fetch owns the port this cycle
- FetchValid  out  1  registered; FetchInst valid this cycle
- FetchInst  out  32  registered instruction for fetch
- DbgReq  in  1  debug request; held with stable DbgAddr until granted
- DbgAddr  in  ADDR_W  debug byte address
- DbgGrant  out  1  combinational; debug owns the port this cycle
- DbgValid  out  1  registered; DbgInst valid this cycle
- DbgInst  out  32  registered instruction for debug
- MemAddr  out  ADDR_W  to instruction memory ReadAddr
- MemInst  in  32  from instruction memory ReadInst (combinational, same cycle)

Behaviour:
- Reset (rst_n=0, asynchronous): FetchValid=0, DbgValid=0, FetchInst=0, DbgInst=0, StarveCnt=0.
  - With rst_n low, FetchGrant=DbgGrant=0 and MemAddr=0.
  - A response in flight when reset asserts is discarded; no Valid pulses after release until a new grant.
- Fetch eligibility: FetchOk = FetchReq & ~Flush.
- Grant, evaluated combinationally each cycle:
  - If DbgReq and (StarveCnt == STARVE_LIMIT or ~FetchOk), then DbgGrant=1.
  - Else if FetchOk, then FetchGrant=1.
  - Else no grant.
  - At most one grant is high per cycle.
- MemAddr:
  - Equals the granted requester's address with bits [1:0] forced to 0.
  - With no grant, MemAddr = 0.
- Latency:
  - Grant in cycle N latches MemInst into the winner's Inst register at the edge ending N.
  - The winner's Valid is 1 for exactly cycle N+1.
  - The loser's Valid is 0 in N+1 and its Inst register holds its previous value.
- Back-to-back grants to the same requester give consecutive Valid cycles with full throughput.
- StarveCnt (4 bits), updated at each edge:
  - DbgGrant: reset to 0.
  - FetchGrant while DbgReq=1: increment, saturating at STARVE_LIMIT.
  - DbgReq=0: reset to 0.
  - Otherwise: hold.
- Forced debug slot: when StarveCnt == STARVE_LIMIT and DbgReq=1, debug wins even with FetchOk=1.
  - FetchGrant=0 in that cycle; the fetch side stalls and retries.
- Flush:
  - With Flush=1 in cycle N, FetchGrant=0 in N and FetchValid=0 in N+1.
  - Debug may take the cycle.
  - Flush does not affect a response already presented in cycle N.
  - Flush with FetchReq=0 has no effect.
- Requesters must not drop a request or change its address before grant.
  - A dropped request is simply not served; there is no error output.
- Address wrap: full ADDR_W address is passed through. Aliasing beyond the memory depth is the memory's concern.

Test Plan:
- Reset release, FetchReq=1, FetchAddr=0x0, DbgReq=0 -> FetchGrant=1, MemAddr=0; next cycle FetchValid=1, FetchInst=0x08100001; DbgValid stays 0.
- Fetch streaming 0x4, 0x8, 0xC on consecutive cycles -> FetchValid high three consecutive cycles with FetchInst 0x20080005, 0x20090005, 0x11080001.
- FetchReq=1 continuously, DbgReq=1, DbgAddr=0x58, STARVE_LIMIT=4:
  - fetch granted 4 cycles, then DbgGrant=1 in the 5th cycle;
  - next cycle DbgValid=1, DbgInst=0x08100005;
  - StarveCnt returns to 0 and fetch resumes.
- FetchReq=1, FetchAddr=0x14, Flush=1 for one cycle, DbgReq=1, DbgAddr=0x5E -> DbgGrant=1, MemAddr=0x5C; next cycle DbgValid=1, DbgInst=0, FetchValid=0.
- Fetch granted at 0x18, rst_n pulsed low mid-cycle before the edge -> outputs clear immediately; FetchValid=0 after release until a new grant; StarveCnt=0.
- FetchReq=0, DbgReq=0, Flush toggling -> no grants, MemAddr=0, no Valid pulses, StarveCnt holds 0.
